// File: rtl/vga_timing_gen_if.sv
// Bus between the VGA timing generator and its neighbours: pixel enable and
// pattern colour in; counters, syncs, data-enable and blanked colour out.
interface vga_timing_gen_if;
    logic        pix_ce;
    logic [3:0]  in_r;
    logic [3:0]  in_g;
    logic [3:0]  in_b;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic [3:0]  o_r;
    logic [3:0]  o_g;
    logic [3:0]  o_b;
    logic        h_sync;
    logic        v_sync;
    logic        de;
    logic        frame_start;

    modport master (
        input  pix_ce, in_r, in_g, in_b,
        output h_cnt, v_cnt, o_r, o_g, o_b, h_sync, v_sync, de, frame_start
    );

    modport slave (
        output pix_ce, in_r, in_g, in_b,
        input  h_cnt, v_cnt, o_r, o_g, o_b, h_sync, v_sync, de, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA pixel timing and output stage: h/v counters, registered syncs and
// blanked colour, all advancing on a pixel clock-enable of the system clock.
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
    localparam logic [10:0] H_ACT_BEG  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_END  = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
    localparam logic [10:0] V_ACT_BEG  = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_ACT_END  = 11'(V_SYNC + V_BACK + V_ACTIVE);

    generate
        if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_size_check
            $error("vga_timing_gen: line or frame total does not fit the 11-bit counters");
        end
    endgenerate

    logic [10:0] h_q;
    logic [10:0] v_q;
    logic [3:0]  r_q;
    logic [3:0]  g_q;
    logic [3:0]  b_q;
    logic        hs_q;
    logic        vs_q;
    logic        de_q;
    logic        fs_q;

    logic h_last;
    logic v_last;
    logic h_act;
    logic v_act;
    logic active;

    assign h_last = (h_q == H_LAST);
    assign v_last = (v_q == V_LAST);
    assign h_act  = (h_q >= H_ACT_BEG) && (h_q < H_ACT_END);
    assign v_act  = (v_q >= V_ACT_BEG) && (v_q < V_ACT_END);
    assign active = h_act && v_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else if (bus.pix_ce) begin
            if (h_last) begin
                h_q <= '0;
                v_q <= v_last ? 11'd0 : v_q + 11'd1;
            end else begin
                h_q <= h_q + 11'd1;
            end
        end
    end

    // Sample the position currently shown on h_cnt/v_cnt together with the
    // pattern colour derived from it, so colour and sync leave aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            de_q <= 1'b0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
        end else if (bus.pix_ce) begin
            r_q  <= active ? bus.in_r : 4'h0;
            g_q  <= active ? bus.in_g : 4'h0;
            b_q  <= active ? bus.in_b : 4'h0;
            de_q <= active;
            hs_q <= (h_q < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            vs_q <= (v_q < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Updated every clk rather than per pixel so the pulse stays one clk wide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_q <= 1'b0;
        end else begin
            fs_q <= bus.pix_ce && h_last && v_last;
        end
    end

    assign bus.h_cnt       = h_q;
    assign bus.v_cnt       = v_q;
    assign bus.o_r         = r_q;
    assign bus.o_g         = g_q;
    assign bus.o_b         = b_q;
    assign bus.h_sync      = hs_q;
    assign bus.v_sync      = vs_q;
    assign bus.de          = de_q;
    assign bus.frame_start = fs_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing and output stage of the VGA path.
- Generates horizontal and vertical counters for the colour-pattern logic, and sync pulses for the connector.
- Takes back the pattern colour computed from those counters, blanks it outside the active area and registers it, so colour and sync leave the block aligned.
- Runs on the system clock with a pixel clock-enable, so no divided clock is needed.

Parameters:
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- SYNC_POL, 0, active sync level (0 = active-low)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- pix_ce  input  1  pixel clock enable; counters and outputs advance only when 1
- in_r  input  4  pattern red for the current h_cnt/v_cnt
- in_g  input  4  pattern green
- in_b  input  4  pattern blue
- h_cnt  output  11  current horizontal position, 0..H_TOTAL-1
- v_cnt  output  11  current vertical position, 0..V_TOTAL-1
- o_r  output  4  registered, blanked red
- o_g  output  4  registered, blanked green
- o_b  output  4  registered, blanked blue
- h_sync  output  1  registered horizontal sync
- v_sync  output  1  registered vertical sync
- de  output  1  registered data-enable; 1 while o_* carry visible pixels
- frame_start  output  1  one-clk pulse at each frame wrap

Behaviour:
- Timing constants:
  - H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT (800).
  - V_TOTAL likewise (525).
  - Both must be ≤ 2047; an elaboration check enforces this.
- Line/frame layout: sync, then back porch, then active, then front porch.
  - Horizontal active: H_SYNC+H_BACK ≤ h_cnt < H_SYNC+H_BACK+H_ACTIVE (144..783).
  - Vertical active uses the same rule (35..514).
- Reset (async, immediate, no clk edge needed):
  - h_cnt = v_cnt = 0.
  - o_r, o_g, o_b = 0; de = 0; frame_start = 0.
  - h_sync and v_sync at the inactive level (~SYNC_POL).
- Counters (update only on clk edges with pix_ce = 1):
  - h_cnt increments, wrapping H_TOTAL-1 → 0.
  - v_cnt increments only on the h_cnt wrap, wrapping V_TOTAL-1 → 0.
  - h_cnt and v_cnt are driven directly from the counter registers, with no extra delay.
- Output stage (updates on clk edges with pix_ce = 1):
  - Samples the position currently on h_cnt/v_cnt together with in_*.
  - h_sync = SYNC_POL when h_cnt < H_SYNC, else ~SYNC_POL.
  - v_sync = SYNC_POL when v_cnt < V_SYNC, else ~SYNC_POL.
  - de = horizontal active AND vertical active.
  - o_* = in_* when active, else 0.
  - Latency: exactly one pix_ce tick from a position appearing on h_cnt/v_cnt to its colour/sync appearing on the outputs.
  - The upstream pattern logic must be combinational from h_cnt/v_cnt.
- When pix_ce = 0, all registers hold their values.
- frame_start:
  - Registered; high for exactly one clk cycle, regardless of pix_ce rate.
  - Asserts in the cycle after the clk edge on which the counters move from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - It is not asserted on reset release.
- Reset released mid-frame: the first pix_ce tick after release samples position (0,0) and then advances the counters to (1,0).
- pix_ce held at 1 is legal (one pixel per clk).

Test Plan:
1. Assert rst mid-line with clk stopped → h_cnt = v_cnt = 0, o_* = 0, de = 0, h_sync = v_sync = 1 immediately.
2. pix_ce = 1 continuously, measured over one line:
   - h_sync low for exactly 96 clk; line period 800 clk.
   - de high for 640 consecutive clk, starting the cycle after the h_cnt = 144 edge.
3. Full frame:
   - v_sync low for 1600 clk.
   - frame period 420000 clk.
   - exactly one single-cycle frame_start per frame.
   - de high on 480 lines.
4. in = {4'hF, 0, 0} constant → o_r = 4'hF only while de = 1; o_r = 0 throughout porches and sync.
5. pix_ce asserted every 4th clk:
   - all periods scale ×4 (line = 3200 clk).
   - outputs hold between ticks.
   - frame_start remains 1 clk wide.
6. in_r driven from h_cnt[3:0] → at the first de pixel o_r = 0 (144 mod 16), then 1, 2, … on successive ticks; confirms one-tick alignment.
